// File: rtl/mulberry_div_slave.sv
// Mulberry bus SID_DIV slave: iterative restoring unsigned divider producing one
// quotient bit per cycle and returning {quotient, remainder} tagged with the requesting MID.
package mulberry_div_slave_pkg;
  localparam int unsigned MID_W = 3;
  typedef logic [MID_W-1:0] mid_t;
  localparam mid_t MID_IDLE       = 3'd0;
  localparam mid_t MID_GPU_CORE   = 3'd1;
  localparam mid_t MID_GPU_LB     = 3'd2;
  localparam mid_t MID_ANTI_ALIAS = 3'd3;
endpackage

module mulberry_div_slave
  import mulberry_div_slave_pkg::*;
#(
  parameter int unsigned P_BUS_DATA_W = 32
) (
  input  logic                    clk_ir,
  input  logic                    rst_il,
  output logic                    busy_o,
  input  logic [P_BUS_DATA_W-1:0] req_data,
  input  mid_t                    req_mid,
  output logic [P_BUS_DATA_W-1:0] rsp_data,
  output mid_t                    rsp_mid
);
  localparam int unsigned N  = P_BUS_DATA_W / 2;
  localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_RSP} state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [N-1:0]  dvd;   // unconsumed dividend bits on top, quotient bits enter at the bottom
  logic [N-1:0]  dvs;
  logic [N-1:0]  rem;
  mid_t          mid;
  logic          dz;    // divide-by-zero result still to be published from RSP

  logic [N:0]    trial;
  logic [N:0]    diff;
  logic          ge;
  logic [N-1:0]  rem_nx;
  logic [N-1:0]  dvd_nx;

  // One restoring step: borrow out of the N+1 bit subtract means trial < divisor.
  always_comb begin
    trial  = {rem, dvd[N-1]};
    diff   = trial - {1'b0, dvs};
    ge     = ~diff[N];
    rem_nx = ge ? diff[N-1:0] : trial[N-1:0];
    dvd_nx = {dvd[N-2:0], ge};
  end

  always_ff @(posedge clk_ir or negedge rst_il) begin
    if (!rst_il) begin
      state    <= S_IDLE;
      cnt      <= '0;
      dvd      <= '0;
      dvs      <= '0;
      rem      <= '0;
      mid      <= MID_IDLE;
      dz       <= 1'b0;
      busy_o   <= 1'b0;
      rsp_data <= '0;
      rsp_mid  <= MID_IDLE;
    end else begin
      case (state)
        S_IDLE: begin
          if (req_mid != MID_IDLE) begin
            dvd    <= req_data[P_BUS_DATA_W-1:N];
            dvs    <= req_data[N-1:0];
            mid    <= req_mid;
            rem    <= '0;
            cnt    <= '0;
            busy_o <= 1'b1;
            if (req_data[N-1:0] == '0) begin
              dz    <= 1'b1;
              state <= S_RSP;
            end else begin
              state <= S_CALC;
            end
          end
        end
        S_CALC: begin
          dvd <= dvd_nx;
          rem <= rem_nx;
          cnt <= cnt + CW'(1);
          if (cnt == CW'(N - 1)) begin
            rsp_data <= {dvd_nx, rem_nx};
            rsp_mid  <= mid;
            state    <= S_RSP;
          end
        end
        S_RSP: begin
          // Divide-by-zero spends one extra RSP cycle so its result lands one edge after capture.
          if (dz) begin
            dz       <= 1'b0;
            rsp_data <= {{N{1'b1}}, dvd};
            rsp_mid  <= mid;
          end else begin
            rsp_data <= '0;
            rsp_mid  <= MID_IDLE;
            busy_o   <= 1'b0;
            state    <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mulberry_div_slave.sv
// Self-checking bench for mulberry_div_slave: directed scenarios plus a randomized
// regression against an arithmetic reference model of quotient/remainder and latency.
module tb_mulberry_div_slave;
  import mulberry_div_slave_pkg::*;

  localparam int unsigned W = 32;
  localparam int unsigned N = W / 2;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         busy;
  logic [W-1:0] req_data;
  mid_t         req_mid;
  logic [W-1:0] rsp_data;
  mid_t         rsp_mid;

  int n_cmp  = 0;
  int n_fail = 0;

  mulberry_div_slave #(.P_BUS_DATA_W(W)) dut (
    .clk_ir  (clk),
    .rst_il  (rst_n),
    .busy_o  (busy),
    .req_data(req_data),
    .req_mid (req_mid),
    .rsp_data(rsp_data),
    .rsp_mid (rsp_mid)
  );

  always #5 clk = ~clk;

  // Reference: plain integer division; divide-by-zero answers {all-ones, dividend}.
  function automatic logic [W-1:0] ref_div(input logic [N-1:0] a, input logic [N-1:0] b);
    logic [N-1:0] q;
    logic [N-1:0] r;
    if (b == '0) return {{N{1'b1}}, a};
    q = a / b;
    r = a % b;
    return {q, r};
  endfunction

  function automatic int ref_lat(input logic [N-1:0] b);
    return (b == '0) ? 1 : int'(N);
  endfunction

  // Present one single-cycle request from idle and observe until busy drops.
  // lat = edges after capture at which the first response is seen; nbusy = busy cycles.
  task automatic run_op(input logic [N-1:0] a, input logic [N-1:0] b, input mid_t m,
                        output logic [W-1:0] d, output mid_t gm, output int lat,
                        output int nrsp, output int nbusy);
    @(negedge clk);
    req_data = {a, b};
    req_mid  = m;
    @(negedge clk);
    req_mid  = MID_IDLE;
    req_data = W'($urandom);
    lat = -1; nrsp = 0; nbusy = 0; d = '0; gm = MID_IDLE;
    for (int k = 0; k < 100; k++) begin
      if (rsp_mid !== MID_IDLE) begin
        nrsp++;
        if (lat < 0) begin
          lat = k;
          d   = rsp_data;
          gm  = rsp_mid;
        end
      end
      if (busy !== 1'b1) break;
      nbusy++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    int stray;
    rst_n = 1'b0; req_mid = MID_IDLE; req_data = '0;
    repeat (3) @(negedge clk);
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_cmp++; if (rsp_mid !== MID_IDLE) begin n_fail++; $display("FAIL reset_mid: got %0d want %0d", rsp_mid, MID_IDLE); end
    n_cmp++; if (rsp_data !== '0) begin n_fail++; $display("FAIL reset_data: got %h want 0", rsp_data); end
    rst_n = 1'b1;
    @(negedge clk);
    req_data = {16'd1000, 16'd3};
    req_mid  = MID_GPU_CORE;
    @(negedge clk);
    req_mid = MID_IDLE;
    repeat (4) @(negedge clk);
    n_cmp++; if (busy !== 1'b1) begin n_fail++; $display("FAIL midcalc_busy: got %b want 1", busy); end
    #2 rst_n = 1'b0;
    #1;
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL async_busy: got %b want 0", busy); end
    n_cmp++; if (rsp_mid !== MID_IDLE) begin n_fail++; $display("FAIL async_mid: got %0d want %0d", rsp_mid, MID_IDLE); end
    n_cmp++; if (rsp_data !== '0) begin n_fail++; $display("FAIL async_data: got %h want 0", rsp_data); end
    @(negedge clk);
    rst_n = 1'b1;
    stray = 0;
    repeat (40) begin
      @(negedge clk);
      if (rsp_mid !== MID_IDLE || busy !== 1'b0) stray++;
    end
    n_cmp++; if (stray != 0) begin n_fail++; $display("FAIL reset_stray: got %0d active cycles want 0", stray); end
  endtask

  task automatic test_basic();
    logic [W-1:0] d; mid_t gm; int lat, nrsp, nbusy;
    run_op(16'd100, 16'd7, MID_GPU_CORE, d, gm, lat, nrsp, nbusy);
    n_cmp++; if (d !== 32'h000E_0002) begin n_fail++; $display("FAIL basic_data: got %h want 000e0002", d); end
    n_cmp++; if (gm !== MID_GPU_CORE) begin n_fail++; $display("FAIL basic_mid: got %0d want %0d", gm, MID_GPU_CORE); end
    n_cmp++; if (lat != 16) begin n_fail++; $display("FAIL basic_lat: got %0d want 16", lat); end
    n_cmp++; if (nrsp != 1) begin n_fail++; $display("FAIL basic_nrsp: got %0d want 1", nrsp); end
    n_cmp++; if (nbusy != 17) begin n_fail++; $display("FAIL basic_busy: got %0d want 17", nbusy); end
  endtask

  task automatic test_div_zero();
    logic [W-1:0] d; mid_t gm; int lat, nrsp, nbusy;
    run_op(16'h1234, 16'h0000, MID_GPU_LB, d, gm, lat, nrsp, nbusy);
    n_cmp++; if (d !== 32'hFFFF_1234) begin n_fail++; $display("FAIL dz_data: got %h want ffff1234", d); end
    n_cmp++; if (gm !== MID_GPU_LB) begin n_fail++; $display("FAIL dz_mid: got %0d want %0d", gm, MID_GPU_LB); end
    n_cmp++; if (lat != 1) begin n_fail++; $display("FAIL dz_lat: got %0d want 1", lat); end
    n_cmp++; if (nrsp != 1) begin n_fail++; $display("FAIL dz_nrsp: got %0d want 1", nrsp); end
    n_cmp++; if (nbusy != 2) begin n_fail++; $display("FAIL dz_busy: got %0d want 2", nbusy); end
  endtask

  task automatic test_extremes();
    logic [N-1:0] ta [3];
    logic [N-1:0] tb [3];
    logic [W-1:0] te [3];
    logic [W-1:0] d; mid_t gm; int lat, nrsp, nbusy;
    ta[0] = 16'hFFFF; tb[0] = 16'h0001; te[0] = 32'hFFFF_0000;
    ta[1] = 16'h0000; tb[1] = 16'h0005; te[1] = 32'h0000_0000;
    ta[2] = 16'h0003; tb[2] = 16'hFFFF; te[2] = 32'h0000_0003;
    for (int i = 0; i < 3; i++) begin
      run_op(ta[i], tb[i], MID_GPU_CORE, d, gm, lat, nrsp, nbusy);
      n_cmp++; if (d !== te[i]) begin n_fail++; $display("FAIL extreme_data[%0d]: got %h want %h", i, d, te[i]); end
      n_cmp++; if (lat != int'(N)) begin n_fail++; $display("FAIL extreme_lat[%0d]: got %0d want %0d", i, lat, N); end
    end
  endtask

  task automatic test_busy_reject();
    int rk [4];
    logic [W-1:0] rd [4];
    mid_t rm [4];
    int nr;
    bit held, release_next;
    for (int i = 0; i < 4; i++) begin rk[i] = -1; rd[i] = '0; rm[i] = MID_IDLE; end
    nr = 0; held = 1'b0; release_next = 1'b0;
    @(negedge clk);
    req_data = 32'h0064_0007;
    req_mid  = MID_GPU_CORE;
    @(negedge clk);
    req_mid = MID_IDLE;
    for (int k = 0; k < 50; k++) begin
      if (rsp_mid !== MID_IDLE) begin
        if (nr < 4) begin rk[nr] = k; rd[nr] = rsp_data; rm[nr] = rsp_mid; end
        nr++;
      end
      if (release_next) begin
        req_mid = MID_IDLE;
        release_next = 1'b0;
        held = 1'b0;
      end else if (held && busy === 1'b0) begin
        release_next = 1'b1;
      end
      if (k == 2) begin
        req_data = 32'h0009_0002;
        req_mid  = MID_ANTI_ALIAS;
        held     = 1'b1;
      end
      @(negedge clk);
    end
    req_mid = MID_IDLE;
    n_cmp++; if (nr != 2) begin n_fail++; $display("FAIL reject_count: got %0d want 2", nr); end
    n_cmp++; if (rk[0] != 16) begin n_fail++; $display("FAIL reject_lat0: got %0d want 16", rk[0]); end
    n_cmp++; if (rd[0] !== 32'h000E_0002) begin n_fail++; $display("FAIL reject_data0: got %h want 000e0002", rd[0]); end
    n_cmp++; if (rm[0] !== MID_GPU_CORE) begin n_fail++; $display("FAIL reject_mid0: got %0d want %0d", rm[0], MID_GPU_CORE); end
    n_cmp++; if (rk[1] != 34) begin n_fail++; $display("FAIL reject_lat1: got %0d want 34", rk[1]); end
    n_cmp++; if (rd[1] !== 32'h0004_0001) begin n_fail++; $display("FAIL reject_data1: got %h want 00040001", rd[1]); end
    n_cmp++; if (rm[1] !== MID_ANTI_ALIAS) begin n_fail++; $display("FAIL reject_mid1: got %0d want %0d", rm[1], MID_ANTI_ALIAS); end
  endtask

  task automatic test_random();
    logic [N-1:0] a, b;
    mid_t m;
    logic [W-1:0] d, exp_d; mid_t gm; int lat, nrsp, nbusy, exp_lat;
    for (int i = 0; i < 2000; i++) begin
      case ($urandom_range(0, 3))
        0:       a = N'($urandom_range(0, 15));
        1:       a = {N{1'b1}} - N'($urandom_range(0, 15));
        default: a = N'($urandom);
      endcase
      case ($urandom_range(0, 7))
        0:       b = '0;
        1:       b = N'(1);
        2:       b = N'($urandom_range(2, 255));
        3:       b = {N{1'b1}} - N'($urandom_range(0, 3));
        default: b = N'($urandom);
      endcase
      m = mid_t'($urandom_range(1, (1 << MID_W) - 1));
      exp_d   = ref_div(a, b);
      exp_lat = ref_lat(b);
      run_op(a, b, m, d, gm, lat, nrsp, nbusy);
      n_cmp++; if (d !== exp_d) begin n_fail++; $display("FAIL rand_data[%0d] %h/%h: got %h want %h", i, a, b, d, exp_d); end
      n_cmp++; if (gm !== m) begin n_fail++; $display("FAIL rand_mid[%0d]: got %0d want %0d", i, gm, m); end
      n_cmp++; if (lat != exp_lat) begin n_fail++; $display("FAIL rand_lat[%0d]: got %0d want %0d", i, lat, exp_lat); end
      n_cmp++; if (nrsp != 1) begin n_fail++; $display("FAIL rand_nrsp[%0d]: got %0d want 1", i, nrsp); end
      n_cmp++; if (nbusy != exp_lat + 1) begin n_fail++; $display("FAIL rand_busy[%0d]: got %0d want %0d", i, nbusy, exp_lat + 1); end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst_n    = 1'b0;
    req_mid  = MID_IDLE;
    req_data = '0;
    test_reset();
    test_basic();
    test_div_zero();
    test_extremes();
    test_busy_reject();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
